// File: rtl/door_sequencer.sv
// Garage-door motion sequencer: a Moore FSM with per-state cycle counters,
// an edge-detected push button and a sticky fault state.
module door_sequencer #(
  parameter int DEAD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int HOLD_CYCLES    = 32
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Activate,
  input  logic       Up_Max,
  input  logic       Dn_Max,
  input  logic       Obstruct,
  output logic       Up_M,
  output logic       Dn_M,
  output logic       Fault,
  output logic [2:0] State
);

  localparam int DEAD_W = $clog2(DEAD_CYCLES) + 1;
  localparam int MOT_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;

  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [MOT_W-1:0]  MOT_LAST  = MOT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_CLOSED    = 3'd0,
    S_OPENING   = 3'd1,
    S_OPEN_HOLD = 3'd2,
    S_CLOSING   = 3'd3,
    S_PAUSED    = 3'd4,
    S_REVERSE   = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic activate_q;
  logic rst_recent_q;
  logic act_pulse;

  logic [DEAD_W-1:0] dead_cnt_q,   dead_cnt_d;
  logic [MOT_W-1:0]  motion_cnt_q, motion_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q,   hold_cnt_d;

  logic sensor_conflict;
  logic motion_done;
  logic hold_done;
  logic dead_done;

  // A button already held when reset releases must not count as a fresh
  // press, so the first cycle after reset never produces a pulse.
  assign act_pulse = Activate & ~activate_q & ~rst_recent_q;

  assign sensor_conflict = Up_Max & Dn_Max;
  assign motion_done     = (motion_cnt_q == MOT_LAST);
  assign hold_done       = (hold_cnt_q == HOLD_LAST);
  assign dead_done       = (dead_cnt_q == DEAD_LAST);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_CLOSED: begin
        if (act_pulse) state_d = S_OPENING;
      end
      S_OPENING: begin
        if (sensor_conflict)  state_d = S_FAULT;
        else if (Up_Max)      state_d = S_OPEN_HOLD;
        else if (motion_done) state_d = S_FAULT;
        else if (act_pulse)   state_d = S_PAUSED;
      end
      S_OPEN_HOLD: begin
        if (sensor_conflict)                        state_d = S_FAULT;
        else if (!Obstruct && (act_pulse || hold_done)) state_d = S_CLOSING;
      end
      S_CLOSING: begin
        if (sensor_conflict)            state_d = S_FAULT;
        else if (Dn_Max)                state_d = S_CLOSED;
        else if (motion_done)           state_d = S_FAULT;
        else if (Obstruct || act_pulse) state_d = S_REVERSE;
      end
      S_PAUSED: begin
        if (act_pulse) state_d = S_CLOSING;
      end
      S_REVERSE: begin
        if (dead_done) state_d = S_OPENING;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  // Counters restart whenever the state changes; the hold timer also
  // restarts while the doorway is obstructed.
  always_comb begin
    dead_cnt_d   = '0;
    motion_cnt_d = '0;
    hold_cnt_d   = '0;
    if (state_d == state_q) begin
      if (state_q == S_REVERSE) dead_cnt_d = dead_cnt_q + 1'b1;
      if (state_q == S_OPENING || state_q == S_CLOSING)
        motion_cnt_d = motion_cnt_q + 1'b1;
      if (state_q == S_OPEN_HOLD && !Obstruct) hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_CLOSED;
      activate_q   <= 1'b0;
      rst_recent_q <= 1'b1;
      dead_cnt_q   <= '0;
      motion_cnt_q <= '0;
      hold_cnt_q   <= '0;
      Up_M         <= 1'b0;
      Dn_M         <= 1'b0;
      Fault        <= 1'b0;
    end else begin
      state_q      <= state_d;
      activate_q   <= Activate;
      rst_recent_q <= 1'b0;
      dead_cnt_q   <= dead_cnt_d;
      motion_cnt_q <= motion_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      Up_M         <= (state_d == S_OPENING);
      Dn_M         <= (state_d == S_CLOSING);
      Fault        <= (state_d == S_FAULT);
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_door_sequencer.sv
// Self-checking bench for door_sequencer: directed scenarios followed by
// random stimulus, all compared against a cycle-age reference model.
module tb_door_sequencer;

  localparam int DEAD    = 4;
  localparam int TIMEOUT = 64;
  localparam int HOLD    = 32;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Activate = 1'b0;
  logic       Up_Max = 1'b0;
  logic       Dn_Max = 1'b0;
  logic       Obstruct = 1'b0;
  logic       Up_M, Dn_M, Fault;
  logic [2:0] State;

  int total = 0;
  int bad   = 0;

  // Reference model: door position as "which phase" plus how long it has
  // been there and how long the doorway has been clear.
  int m_state = 0;
  int m_age   = 0;
  int m_quiet = 0;
  bit m_btn_prev = 0;
  bit m_fresh_reset = 0;

  int seen [7];
  int up_cycles;

  door_sequencer #(
    .DEAD_CYCLES(DEAD), .TIMEOUT_CYCLES(TIMEOUT), .HOLD_CYCLES(HOLD)
  ) dut (
    .CLK(CLK), .RST(RST), .Activate(Activate), .Up_Max(Up_Max),
    .Dn_Max(Dn_Max), .Obstruct(Obstruct), .Up_M(Up_M), .Dn_M(Dn_M),
    .Fault(Fault), .State(State)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_update();
    bit press;
    int nxt;
    if (RST) begin
      m_state = 0; m_age = 0; m_quiet = 0;
      m_btn_prev = 0; m_fresh_reset = 1;
      return;
    end
    press = Activate && !m_btn_prev && !m_fresh_reset;
    m_btn_prev = Activate;
    m_fresh_reset = 0;
    nxt = m_state;
    case (m_state)
      0: if (press) nxt = 1;
      1: if (Up_Max && Dn_Max) nxt = 6;
         else if (Up_Max) nxt = 2;
         else if (m_age + 1 >= TIMEOUT) nxt = 6;
         else if (press) nxt = 4;
      2: if (Up_Max && Dn_Max) nxt = 6;
         else if (!Obstruct && (press || m_quiet + 1 >= HOLD)) nxt = 3;
      3: if (Up_Max && Dn_Max) nxt = 6;
         else if (Dn_Max) nxt = 0;
         else if (m_age + 1 >= TIMEOUT) nxt = 6;
         else if (Obstruct || press) nxt = 5;
      4: if (press) nxt = 3;
      5: if (m_age + 1 >= DEAD) nxt = 1;
      default: nxt = 6;
    endcase
    if (nxt != m_state) begin
      m_age = 0; m_quiet = 0;
    end else begin
      m_age++;
      m_quiet = Obstruct ? 0 : m_quiet + 1;
    end
    m_state = nxt;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    model_update();
    check("state", 32'(State), 32'(m_state));
    check("up_m",  32'(Up_M),  32'(m_state == 1));
    check("dn_m",  32'(Dn_M),  32'(m_state == 3));
    check("fault", 32'(Fault), 32'(m_state == 6));
    if (State <= 3'd6) seen[State]++;
    if (Up_M) up_cycles++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press();
    Activate = 1'b1;
    step();
    Activate = 1'b0;
  endtask

  task automatic clear_seen();
    for (int i = 0; i < 7; i++) seen[i] = 0;
    up_cycles = 0;
  endtask

  task automatic run_until(input string tag, input logic [2:0] target, input int budget);
    bit reached = 0;
    for (int i = 0; i < budget && !reached; i++) begin
      step();
      if (State == target) reached = 1;
    end
    check(tag, 32'(reached), 32'd1);
  endtask

  initial begin
    clear_seen();
    // Reset and idle
    steps(2);
    check("reset_state", 32'(State), 32'd0);
    check("reset_fault", 32'(Fault), 32'd0);
    RST = 1'b0;
    step();

    // Full open / hold / close cycle with the button held 30 cycles
    Dn_Max = 1'b1;
    clear_seen();
    for (int i = 0; i < 30; i++) begin
      Activate = 1'b1;
      if (i == 19) Up_Max = 1'b1;
      step();
      if (i == 0) begin
        check("open_up_m", 32'(Up_M), 32'd1);
        check("open_dn_m", 32'(Dn_M), 32'd0);
        Dn_Max = 1'b0;
      end
    end
    Activate = 1'b0;
    run_until("reach_closing", 3'd3, 100);
    check("single_opening", 32'(seen[1]), 32'd19);
    check("hold_len", 32'(seen[2]), 32'(HOLD));
    check("closing_dn_m", 32'(Dn_M), 32'd1);
    Up_Max = 1'b0;
    steps(3);
    Dn_Max = 1'b1;
    step();
    check("closed", 32'(State), 32'd0);

    // Obstruction while closing reverses after the dead time
    Dn_Max = 1'b0;
    press();
    Up_Max = 1'b1;
    step();
    check("hold_again", 32'(State), 32'd2);
    press();
    check("closing_by_button", 32'(State), 32'd3);
    Up_Max = 1'b0;
    steps(3);
    clear_seen();
    Obstruct = 1'b1;
    step();
    Obstruct = 1'b0;
    check("reverse", 32'(State), 32'd5);
    run_until("reach_reopen", 3'd1, 20);
    check("dead_len", 32'(seen[5]), 32'(DEAD));
    check("reopen_up_m", 32'(Up_M), 32'd1);

    // Obstruction late in the hold restarts the timer
    Up_Max = 1'b1;
    step();
    steps(30);
    clear_seen();
    Obstruct = 1'b1;
    step();
    Obstruct = 1'b0;
    run_until("reach_closing2", 3'd3, 100);
    check("hold_restart_len", 32'(seen[2]), 32'(HOLD));
    Up_Max = 1'b0;
    Dn_Max = 1'b1;
    step();
    check("closed2", 32'(State), 32'd0);

    // Opening without reaching the top times out into FAULT
    Dn_Max = 1'b0;
    clear_seen();
    press();
    run_until("reach_fault", 3'd6, 200);
    check("up_m_cycles", 32'(up_cycles), 32'(TIMEOUT));
    check("fault_flag", 32'(Fault), 32'd1);
    press();
    steps(2);
    check("fault_sticky", 32'(State), 32'd6);
    RST = 1'b1;
    step();
    check("fault_cleared_state", 32'(State), 32'd0);
    check("fault_cleared_flag", 32'(Fault), 32'd0);
    RST = 1'b0;
    step();

    // Pause, resume downward, then a sensor conflict
    press();
    steps(3);
    press();
    check("paused", 32'(State), 32'd4);
    check("paused_up_m", 32'(Up_M), 32'd0);
    steps(5);
    check("paused_still", 32'(State), 32'd4);
    press();
    check("resume_closing", 32'(State), 32'd3);
    Up_Max = 1'b1;
    Dn_Max = 1'b1;
    step();
    check("conflict_fault", 32'(State), 32'd6);
    Up_Max = 1'b0;
    Dn_Max = 1'b0;
    RST = 1'b1;
    step();
    RST = 1'b0;
    step();

    // Reset mid-closing with the button held across release
    press();
    Up_Max = 1'b1;
    step();
    press();
    Up_Max = 1'b0;
    steps(2);
    check("pre_reset_closing", 32'(State), 32'd3);
    RST = 1'b1;
    Activate = 1'b1;
    step();
    check("rst_state", 32'(State), 32'd0);
    check("rst_dn_m", 32'(Dn_M), 32'd0);
    RST = 1'b0;
    steps(5);
    check("held_no_open", 32'(State), 32'd0);
    Activate = 1'b0;
    step();

    // Random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      RST      = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 7) == 0) Activate = ~Activate;
      Up_Max   = ($urandom_range(0, 15) == 0);
      Dn_Max   = ($urandom_range(0, 15) == 0);
      Obstruct = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
